lut_mem_loader: RTL and testbench
=================================

// Module: lut_mem_loader
// PURPOSE
//  Memory-mapped initiator that fills an accelerator unit's internal tables (e.g. S-box LookupTable pairs).
//  Drives the unit-side valid/addr/wstrb/wdata/ready/rdata config interface.
//  Takes a start command, pulls words from a valid/ready source stream and issues one write per word.
//  Writes go to consecutive addresses starting at base_addr. Sits between the host/DMA stream and a unit's config port.
// PARAMETERS
//  DATA_W   32  data word width (wstrb width = DATA_W/8)
//  ADDR_W   9   unit address width (bit MSB selects table, as in two-table units)
//  LEN_W    10  width of word-count field
// PORTS
//  clk         in   1          single clock, rising edge
//  rst         in   1          asynchronous, active-low reset
//  start       in   1          1-cycle command pulse; sampled only in IDLE
//  base_addr   in   ADDR_W     first target address; sampled with start
//  length      in   LEN_W      number of words to load; sampled with start
//  busy        out  1          high from cycle after accepted start until done
//  done        out  1          1-cycle pulse at end of operation
//  error       out  1          readback checksum mismatch (VERIFY_EN only), held until next accepted start
//  s_valid     in   1          source word available
//  s_data      in   DATA_W     source word
//  s_ready     out  1          loader accepts s_data this cycle
//  m_valid     out  1          transaction request to unit
//  m_addr      out  ADDR_W     transaction address
//  m_wstrb     out  DATA_W/8   all-ones = write, zero = read
//  m_wdata     out  DATA_W     write data
//  m_ready     in   1          unit completes transaction this cycle
//  m_rdata     in   DATA_W     read data, valid when m_valid&&m_ready with m_wstrb==0
// BEHAVIOUR
//  Reset: busy=0 done=0 error=0 s_ready=0 m_valid=0 m_addr=0 m_wstrb=0 m_wdata=0; FSM=IDLE, idx=0, checksums=0.
//  FSM states IDLE, FETCH, WRITE, READ (READ exists only with VERIFY_EN), FINISH.
//  IDLE:
//   - start=1 latches base_addr/length, clears idx, checksums and error.
//   - length==0 -> FINISH; else -> FETCH.
//   - start in any other state is ignored.
//  FETCH:
//   - s_ready=1 (combinational from state).
//   - On s_valid&&s_ready: register m_wdata=s_data, m_addr=base+idx, m_wstrb=all-ones, m_valid=1; go WRITE.
//  WRITE:
//   - m_valid, m_addr, m_wstrb, m_wdata held stable until m_valid&&m_ready.
//   - On completion: m_valid=0, wr_chk ^= m_wdata, idx++.
//   - If idx+1==length -> READ (VERIFY_EN) or FINISH; else -> FETCH.
//  Timing:
//   - Word accepted at cycle N -> m_valid high at N+1.
//   - With m_ready tied high, one word per 2 cycles.
//  Address arithmetic:
//   - m_addr = (base_addr + idx) mod 2^ADDR_W; wraps silently past all-ones.
//   - idx is LEN_W bits wide; length = 2^LEN_W-1 is the maximum.
//  FINISH: done=1 for exactly one cycle, busy=0 the same cycle, -> IDLE.
//  busy rises the cycle after start, including for length==0.
//  Source stalls (s_valid=0) and unit stalls (m_ready=0) are unbounded; no timeout.
//  Reset asserted mid-operation returns everything to reset values immediately; the in-flight transaction is abandoned.
// CONFIGURATION
//  LUT_LOADER_VERIFY_EN defined:
//   - After the last write, idx=0 and the FSM enters READ.
//   - READ issues m_valid=1, m_wstrb=0, m_addr=base+idx; on m_ready: rd_chk ^= m_rdata, idx++.
//   - After length reads, error <= (rd_chk != wr_chk), then FINISH. error is updated in the same cycle done pulses.
//  LUT_LOADER_VERIFY_EN undefined:
//   - No READ state, no checksum registers; error tied 0; m_wstrb never zero while m_valid.
// TESTING
//  T1: base=0x000, len=4, words 0x63,0x7C,0x77,0x7B, m_ready=1
//      -> writes addr 0..3 with those data, done 1 cycle after 4th write, busy low, error=0.
//  T2: base=0x1FE, len=4 -> addresses 0x1FE,0x1FF,0x000,0x001 (wrap).
//  T3: len=0 -> busy 1 cycle, done pulse, zero m_valid cycles, s_ready never high.
//  T4: m_ready low 5 cycles per write, s_valid gaps of 3 cycles
//      -> m_addr/m_wdata/m_wstrb stable while m_valid&&!m_ready; all data delivered in order.
//  T5 (VERIFY_EN): len=2, data 0xA5,0x5A; model returns 0xA5,0x5B on readback
//      -> two reads at base,base+1 with wstrb=0; error=1 at done.
//      Correct readback gives error=0.
//  T6: assert rst low mid-WRITE after word 2 of 8 -> all outputs to reset values.
//      New start with len=1 then completes normally; start pulsed while busy is ignored.

Source files
------------

// File: rtl/lut_mem_loader_if.sv
// Source stream and unit config-port signals for lut_mem_loader.
// master = loader side, slave = host stream plus target unit.
interface lut_mem_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic                  s_valid;
  logic [DATA_W-1:0]     s_data;
  logic                  s_ready;
  logic                  m_valid;
  logic [ADDR_W-1:0]     m_addr;
  logic [DATA_W/8-1:0]   m_wstrb;
  logic [DATA_W-1:0]     m_wdata;
  logic                  m_ready;
  logic [DATA_W-1:0]     m_rdata;

  modport master (
    input  s_valid, s_data,
    input  m_ready, m_rdata,
    output s_ready,
    output m_valid, m_addr,
    output m_wstrb, m_wdata
  );

  modport slave (
    output s_valid, s_data,
    output m_ready, m_rdata,
    input  s_ready,
    input  m_valid, m_addr,
    input  m_wstrb, m_wdata
  );
endinterface

// File: rtl/lut_mem_loader.sv
// Streams source words into consecutive unit table addresses.
// Define LUT_LOADER_VERIFY_EN to add an XOR-checksum readback pass.
module lut_mem_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              error,
  lut_mem_loader_if.master  bus
);
  localparam int STRB_W = DATA_W / 8;

`ifdef LUT_LOADER_VERIFY_EN
  typedef enum logic [2:0] {
    IDLE, FETCH, WRITE, READ, FINISH
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, FETCH, WRITE, FINISH
  } state_t;
`endif

  state_t              state;
  logic [ADDR_W-1:0]   base_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    idx;
  logic                last;
  logic                m_valid;
  logic [ADDR_W-1:0]   m_addr;
  logic [STRB_W-1:0]   m_wstrb;
  logic [DATA_W-1:0]   m_wdata;

  assign last        = (idx == len_q - LEN_W'(1));
  assign bus.s_ready = (state == FETCH);
  assign bus.m_valid = m_valid;
  assign bus.m_addr  = m_addr;
  assign bus.m_wstrb = m_wstrb;
  assign bus.m_wdata = m_wdata;

`ifdef LUT_LOADER_VERIFY_EN
  logic [DATA_W-1:0] wr_chk;
  logic [DATA_W-1:0] rd_chk;
  logic              err_q;
  assign error = err_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^bus.m_rdata;
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      m_valid <= 1'b0;
      m_addr  <= '0;
      m_wstrb <= '0;
      m_wdata <= '0;
`ifdef LUT_LOADER_VERIFY_EN
      wr_chk  <= '0;
      rd_chk  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            len_q  <= length;
            idx    <= '0;
            busy   <= 1'b1;
`ifdef LUT_LOADER_VERIFY_EN
            wr_chk <= '0;
            rd_chk <= '0;
            err_q  <= 1'b0;
`endif
            state  <= (length == '0) ? FINISH : FETCH;
          end
        end
        FETCH: begin
          if (bus.s_valid) begin
            m_valid <= 1'b1;
            m_addr  <= base_q + ADDR_W'(idx);
            m_wstrb <= '1;
            m_wdata <= bus.s_data;
            state   <= WRITE;
          end
        end
        WRITE: begin
          if (bus.m_ready) begin
            m_valid <= 1'b0;
            idx     <= idx + LEN_W'(1);
`ifdef LUT_LOADER_VERIFY_EN
            wr_chk  <= wr_chk ^ m_wdata;
`endif
            if (last) begin
`ifdef LUT_LOADER_VERIFY_EN
              // Readback pass restarts at base with a read strobe
              idx     <= '0;
              m_valid <= 1'b1;
              m_wstrb <= '0;
              m_addr  <= base_q;
              state   <= READ;
`else
              state   <= FINISH;
`endif
            end else begin
              state <= FETCH;
            end
          end
        end
`ifdef LUT_LOADER_VERIFY_EN
        READ: begin
          if (bus.m_ready) begin
            rd_chk <= rd_chk ^ bus.m_rdata;
            idx    <= idx + LEN_W'(1);
            if (last) begin
              m_valid <= 1'b0;
              state   <= FINISH;
            end else begin
              m_addr <= base_q
                + ADDR_W'(idx + LEN_W'(1));
            end
          end
        end
`endif
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
`ifdef LUT_LOADER_VERIFY_EN
          err_q <= (rd_chk != wr_chk);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lut_mem_loader.sv
// Scoreboard bench for lut_mem_loader: directed loads,
// address wrap, stalls, reset abort and optional readback.
`timescale 1ns/1ps
module tb_lut_mem_loader;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int LEN_W  = 10;
  localparam int STRB_W = DATA_W / 8;
`ifdef LUT_LOADER_VERIFY_EN
  localparam int T1_CYC = -1;
`else
  localparam int T1_CYC = 10;
`endif

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] strb;
    logic [DATA_W-1:0] data;
    logic              rd;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              busy;
  logic              done;
  logic              error;

  lut_mem_loader_if #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) bus ();

  lut_mem_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .error(error),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  txn_t              exp_q[$];
  int                n_cmp = 0;
  int                n_bad = 0;
  logic [DATA_W-1:0] mem [0:511];
  logic [DATA_W-1:0] words [0:15];
  int                stall_n = 0;
  int                wait_cnt = 0;
  int                mv_cnt = 0;
  int                sr_cnt = 0;
  logic              corrupt_en = 1'b0;
  logic [ADDR_W-1:0] corrupt_addr = '0;
  logic              pv = 1'b0;
  logic [ADDR_W-1:0] pa;
  logic [STRB_W-1:0] ps;
  logic [DATA_W-1:0] pd;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  // Unit model and monitor: drives m_ready/m_rdata, checks txns
  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bus.m_ready = 1'b0;
        wait_cnt = 0;
        pv = 1'b0;
      end else begin
        if (bus.m_valid) mv_cnt++;
        if (bus.s_ready) sr_cnt++;
        if (pv)
          check("hold_stable",
            {bus.m_valid, bus.m_addr, bus.m_wstrb, bus.m_wdata},
            {1'b1, pa, ps, pd});
        if (bus.m_ready || !bus.m_valid) wait_cnt = 0;
        if (bus.m_valid && wait_cnt >= stall_n) begin
          bus.m_ready = 1'b1;
        end else begin
          bus.m_ready = 1'b0;
          if (bus.m_valid) wait_cnt++;
        end
        bus.m_rdata = mem[bus.m_addr];
        if (corrupt_en && bus.m_addr == corrupt_addr)
          bus.m_rdata[0] = ~bus.m_rdata[0];
        pv = bus.m_valid && !bus.m_ready;
        pa = bus.m_addr;
        ps = bus.m_wstrb;
        pd = bus.m_wdata;
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_txn: got addr %0h want none",
                     bus.m_addr);
          end else begin
            txn_t e;
            e = exp_q.pop_front();
            check("txn_addr", bus.m_addr, e.addr);
            check("txn_strb", bus.m_wstrb, e.strb);
            if (!e.rd) check("txn_data", bus.m_wdata, e.data);
          end
          if (bus.m_wstrb != '0) mem[bus.m_addr] = bus.m_wdata;
        end
      end
    end
  end

  task automatic push_exp(input logic [ADDR_W-1:0] base,
                          input int len);
    txn_t t;
    for (int i = 0; i < len; i++) begin
      t.addr = base + ADDR_W'(i);
      t.strb = '1;
      t.data = words[i];
      t.rd   = 1'b0;
      exp_q.push_back(t);
    end
`ifdef LUT_LOADER_VERIFY_EN
    for (int i = 0; i < len; i++) begin
      t.addr = base + ADDR_W'(i);
      t.strb = '0;
      t.data = '0;
      t.rd   = 1'b1;
      exp_q.push_back(t);
    end
`endif
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] base,
                             input int len,
                             output int t0);
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    length = LEN_W'(len);
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed_word(input logic [DATA_W-1:0] d);
    bit ok;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    for (int k = 0; k < 300; k++) begin
      if (bus.s_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL feed_timeout: got no s_ready want s_ready");
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done(input logic exp_err,
                           input int exp_cyc,
                           input int t0);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("busy_at_done", busy, 0);
      check("error_at_done", error, exp_err);
      if (exp_cyc >= 0)
        check("start_to_done", cyc - t0, exp_cyc);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("error_held", error, exp_err);
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic run_op(input logic [ADDR_W-1:0] base,
                        input int len, input int gap,
                        input int stall, input logic exp_err,
                        input int exp_cyc);
    int t0;
    stall_n = stall;
    push_exp(base, len);
    pulse_start(base, len, t0);
    check("busy_after_start", busy, 1);
    for (int i = 0; i < len; i++) begin
      feed_word(words[i]);
      if (gap > 0 && i < len - 1) repeat (gap) @(negedge clk);
    end
    wait_done(exp_err, exp_cyc, t0);
  endtask

  task automatic check_reset_vals(input string name);
    check(name,
      {busy, done, error, bus.s_ready, bus.m_valid,
       bus.m_addr, bus.m_wstrb, bus.m_wdata}, 64'h0);
  endtask

  initial begin
    int t0;
    int mv0;
    int sr0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_state");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // T1: basic S-box fill at base 0
    words[0] = 32'h63; words[1] = 32'h7C;
    words[2] = 32'h77; words[3] = 32'h7B;
    run_op(9'h000, 4, 0, 0, 1'b0, T1_CYC);

    // T2: address wrap past 0x1FF
    words[0] = 32'h1111_0001; words[1] = 32'h2222_0002;
    words[2] = 32'h3333_0003; words[3] = 32'h4444_0004;
    run_op(9'h1FE, 4, 0, 0, 1'b0, T1_CYC);

    // T3: zero length
    mv0 = mv_cnt;
    sr0 = sr_cnt;
    run_op(9'h055, 0, 0, 0, 1'b0, 2);
    check("len0_m_valid_cycles", mv_cnt - mv0, 0);
    check("len0_s_ready_cycles", sr_cnt - sr0, 0);

    // T4: unit stalls and source gaps
    words[0] = 32'hDEAD_BEEF; words[1] = 32'h0BAD_F00D;
    words[2] = 32'h1234_5678; words[3] = 32'h8765_4321;
    words[4] = 32'hCAFE_0000;
    run_op(9'h040, 5, 3, 5, 1'b0, -1);

`ifdef LUT_LOADER_VERIFY_EN
    // T5: readback mismatch then clean readback
    words[0] = 32'hA5; words[1] = 32'h5A;
    corrupt_addr = 9'h101;
    corrupt_en = 1'b1;
    run_op(9'h100, 2, 0, 0, 1'b1, -1);
    corrupt_en = 1'b0;
    run_op(9'h100, 2, 0, 0, 1'b0, -1);
`endif

    // T6: reset while the third write is stalled
    for (int i = 0; i < 8; i++)
      words[i] = 32'hA000_0000 + i;
    stall_n = 3;
    push_exp(9'h020, 2);
    exp_q = exp_q[0:1];
    pulse_start(9'h020, 8, t0);
    feed_word(words[0]);
    feed_word(words[1]);
    feed_word(words[2]);
    #2 rst = 1'b0;
    #1 check_reset_vals("reset_mid_write");
    check("abort_drained", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b1;
    stall_n = 0;
    words[0] = 32'h3C;
    push_exp(9'h010, 1);
    pulse_start(9'h010, 1, t0);
    start = 1'b1;
    base_addr = 9'h0AA;
    length = 10'd5;
    @(negedge clk);
    start = 1'b0;
    feed_word(words[0]);
    wait_done(1'b0, -1, t0);
    repeat (4) @(negedge clk);
    check("idle_after_ignored_start", {busy, bus.m_valid}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
